// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries fetch-time prediction metadata through IF/ID and ID/EX,
// checks it against the EX outcome and drives redirect, flush, predictor training and perf counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_valid,
  input  logic [XLEN-1:0]      if_pc,
  input  logic                 if_pred_taken,
  input  logic [XLEN-1:0]      if_pred_pc,
  input  logic                 stall,
  input  logic                 ex_is_cond,
  input  logic                 ex_is_jal,
  input  logic                 ex_is_jalr,
  input  logic                 ex_cond_true,
  input  logic [XLEN-1:0]      ex_target,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 flush,
  output logic                 update_en,
  output logic                 actual_taken,
  output logic [XLEN-1:0]      ex_pc,
  output logic                 ex_meta_valid,
  output logic [CNT_WIDTH-1:0] cnt_branches,
  output logic [CNT_WIDTH-1:0] cnt_mispred
);

  localparam logic [XLEN-1:0]      PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0]      PC_ZERO = {XLEN{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 id_valid_q, id_valid_d;
  logic [XLEN-1:0]      id_pc_q, id_pc_d;
  logic                 id_pred_taken_q, id_pred_taken_d;
  logic [XLEN-1:0]      id_pred_pc_q, id_pred_pc_d;
  logic                 ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]      ex_pc_q, ex_pc_d;
  logic                 ex_pred_taken_q, ex_pred_taken_d;
  logic [XLEN-1:0]      ex_pred_pc_q, ex_pred_pc_d;
  logic [CNT_WIDTH-1:0] cnt_branches_q, cnt_branches_d;
  logic [CNT_WIDTH-1:0] cnt_mispred_q, cnt_mispred_d;

  logic                 actual_taken_s;
  logic                 mispredict_s;
  logic                 update_en_s;
  logic [XLEN-1:0]      correct_pc_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    logic [CNT_WIDTH-1:0] r;
    if (en && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Resolve the EX slot: outcome, correct next PC and mispredict; everything quiet for a bubble.
  always_comb begin
    actual_taken_s = 1'b0;
    mispredict_s   = 1'b0;
    update_en_s    = 1'b0;
    correct_pc_s   = PC_ZERO;
    if (ex_valid_q) begin
      actual_taken_s = ex_is_jal | ex_is_jalr | (ex_is_cond & ex_cond_true);
      update_en_s    = ex_is_cond;
      if (actual_taken_s) begin
        correct_pc_s = ex_target;
      end else begin
        correct_pc_s = ex_pc_q + PC_STEP;
      end
      // A wrong target only matters when the branch really was taken.
      mispredict_s = (actual_taken_s != ex_pred_taken_q) |
                     (actual_taken_s & (ex_pred_pc_q != ex_target));
    end else begin
      actual_taken_s = 1'b0;
      mispredict_s   = 1'b0;
    end
  end

  // Slot advance: a redirect kills both slots even when stalled; a stall bubbles EX.
  always_comb begin
    id_valid_d      = id_valid_q;
    id_pc_d         = id_pc_q;
    id_pred_taken_d = id_pred_taken_q;
    id_pred_pc_d    = id_pred_pc_q;
    ex_valid_d      = ex_valid_q;
    ex_pc_d         = ex_pc_q;
    ex_pred_taken_d = ex_pred_taken_q;
    ex_pred_pc_d    = ex_pred_pc_q;
    if (mispredict_s) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
    end else if (stall) begin
      ex_valid_d = 1'b0;
    end else begin
      id_valid_d      = if_valid;
      id_pc_d         = if_pc;
      id_pred_taken_d = if_pred_taken;
      id_pred_pc_d    = if_pred_pc;
      ex_valid_d      = id_valid_q;
      ex_pc_d         = id_pc_q;
      ex_pred_taken_d = id_pred_taken_q;
      ex_pred_pc_d    = id_pred_pc_q;
    end
  end

  // Saturating performance counters.
  always_comb begin
    cnt_branches_d = sat_inc(cnt_branches_q, update_en_s);
    cnt_mispred_d  = sat_inc(cnt_mispred_q, mispredict_s);
  end

  // Pipeline metadata and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_q      <= 1'b0;
      id_pc_q         <= PC_ZERO;
      id_pred_taken_q <= 1'b0;
      id_pred_pc_q    <= PC_ZERO;
      ex_valid_q      <= 1'b0;
      ex_pc_q         <= PC_ZERO;
      ex_pred_taken_q <= 1'b0;
      ex_pred_pc_q    <= PC_ZERO;
      cnt_branches_q  <= {CNT_WIDTH{1'b0}};
      cnt_mispred_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      id_valid_q      <= id_valid_d;
      id_pc_q         <= id_pc_d;
      id_pred_taken_q <= id_pred_taken_d;
      id_pred_pc_q    <= id_pred_pc_d;
      ex_valid_q      <= ex_valid_d;
      ex_pc_q         <= ex_pc_d;
      ex_pred_taken_q <= ex_pred_taken_d;
      ex_pred_pc_q    <= ex_pred_pc_d;
      cnt_branches_q  <= cnt_branches_d;
      cnt_mispred_q   <= cnt_mispred_d;
    end
  end

  assign redirect_valid = mispredict_s;
  assign flush          = mispredict_s;
  assign redirect_pc    = correct_pc_s;
  assign update_en      = update_en_s;
  assign actual_taken   = actual_taken_s;
  assign ex_pc          = ex_pc_q;
  assign ex_meta_valid  = ex_valid_q;
  assign cnt_branches   = cnt_branches_q;
  assign cnt_mispred    = cnt_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed plan scenarios plus random traffic against a
// slot-level reference model; a narrow-counter instance exercises counter saturation.
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_pc;
  logic        stall;
  logic        ex_is_cond;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        ex_cond_true;
  logic [31:0] ex_target;

  logic        rv_s, fl_s, upd_s, at_s, mv_s;
  logic [31:0] rpc_s, epc_s, cb_s, cm_s;
  logic        n_rv_s, n_fl_s, n_upd_s, n_at_s, n_mv_s;
  logic [31:0] n_rpc_s, n_epc_s;
  logic [1:0]  n_cb_s, n_cm_s;

  branch_resolve_unit #(.XLEN(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_pred_pc(if_pred_pc), .stall(stall),
    .ex_is_cond(ex_is_cond), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_cond_true(ex_cond_true), .ex_target(ex_target),
    .redirect_valid(rv_s), .redirect_pc(rpc_s), .flush(fl_s), .update_en(upd_s),
    .actual_taken(at_s), .ex_pc(epc_s), .ex_meta_valid(mv_s),
    .cnt_branches(cb_s), .cnt_mispred(cm_s)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_WIDTH(2)) dut_narrow (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_pred_pc(if_pred_pc), .stall(stall),
    .ex_is_cond(ex_is_cond), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_cond_true(ex_cond_true), .ex_target(ex_target),
    .redirect_valid(n_rv_s), .redirect_pc(n_rpc_s), .flush(n_fl_s), .update_en(n_upd_s),
    .actual_taken(n_at_s), .ex_pc(n_epc_s), .ex_meta_valid(n_mv_s),
    .cnt_branches(n_cb_s), .cnt_mispred(n_cm_s)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ppc;
  } slot_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        upd;
    logic        at;
    logic [31:0] epc;
    logic        mv;
    longint      cb;
    longint      cm;
  } exp_t;

  slot_t  m_id, m_ex;
  longint m_cb, m_cm;
  exp_t   exp_q[$];
  int     n_checks;
  int     n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock: drive inputs after the edge, predict this cycle's outputs, then advance the model.
  task automatic step(input logic ifv, input logic [31:0] ipc, input logic ipt, input logic [31:0] ippc,
                      input logic stl, input int kind, input logic ct, input logic [31:0] tgt,
                      input logic rst_in);
    exp_t e;
    logic taken, mis;
    @(posedge clk);
    #1;
    reset = rst_in; if_valid = ifv; if_pc = ipc; if_pred_taken = ipt; if_pred_pc = ippc;
    stall = stl; ex_is_cond = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
    ex_cond_true = ct; ex_target = tgt;
    if (rst_in) begin
      m_id = '{1'b0, 32'h0, 1'b0, 32'h0};
      m_ex = '{1'b0, 32'h0, 1'b0, 32'h0};
      m_cb = 0;
      m_cm = 0;
    end
    taken = m_ex.v && ((kind == 2) || (kind == 3) || ((kind == 1) && ct));
    mis   = m_ex.v && ((taken != m_ex.pt) || (taken && (m_ex.ppc != tgt)));
    e.rv  = mis;
    e.rpc = taken ? tgt : (m_ex.pc + 32'd4);
    e.upd = m_ex.v && (kind == 1);
    e.at  = taken;
    e.epc = m_ex.pc;
    e.mv  = m_ex.v;
    e.cb  = m_cb;
    e.cm  = m_cm;
    exp_q.push_back(e);
    if (!rst_in) begin
      if (e.upd) m_cb++;
      if (mis) m_cm++;
      if (mis) begin
        m_id.v = 1'b0;
        m_ex.v = 1'b0;
      end else if (stl) begin
        m_ex.v = 1'b0;
      end else begin
        m_ex = m_id;
        m_id = '{ifv, ipc, ipt, ippc};
      end
    end
  endtask

  task automatic idle(input logic stl);
    step(1'b0, 32'h0, 1'b0, 32'h0, stl, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rand_step();
    int          k;
    logic        ct;
    logic [31:0] tgt;
    logic [31:0] ipc;
    k   = $urandom_range(3);
    ct  = ($urandom_range(1) == 1) ? m_ex.pt : 1'($urandom_range(1));
    tgt = ($urandom_range(1) == 1) ? m_ex.ppc : ($urandom & 32'hFFFF_FFFC);
    ipc = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    step(1'($urandom_range(3) != 0), ipc, 1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC,
         1'($urandom_range(3) == 0), k, ct, tgt, 1'b0);
  endtask

  // Monitor: pop one expectation per cycle and compare both instances mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("redirect_valid", {31'd0, rv_s}, {31'd0, e.rv});
        chk("flush", {31'd0, fl_s}, {31'd0, e.rv});
        chk("update_en", {31'd0, upd_s}, {31'd0, e.upd});
        chk("actual_taken", {31'd0, at_s}, {31'd0, e.at});
        chk("ex_meta_valid", {31'd0, mv_s}, {31'd0, e.mv});
        chk("cnt_branches", cb_s, 32'(sat(e.cb, 64'hFFFF_FFFF)));
        chk("cnt_mispred", cm_s, 32'(sat(e.cm, 64'hFFFF_FFFF)));
        if (e.rv) chk("redirect_pc", rpc_s, e.rpc);
        if (e.mv) chk("ex_pc", epc_s, e.epc);
        chk("n_redirect_valid", {31'd0, n_rv_s}, {31'd0, e.rv});
        chk("n_flush", {31'd0, n_fl_s}, {31'd0, e.rv});
        chk("n_update_en", {31'd0, n_upd_s}, {31'd0, e.upd});
        chk("n_actual_taken", {31'd0, n_at_s}, {31'd0, e.at});
        chk("n_ex_meta_valid", {31'd0, n_mv_s}, {31'd0, e.mv});
        chk("n_cnt_branches", {30'd0, n_cb_s}, 32'(sat(e.cb, 64'd3)));
        chk("n_cnt_mispred", {30'd0, n_cm_s}, 32'(sat(e.cm, 64'd3)));
        if (e.rv) chk("n_redirect_pc", n_rpc_s, e.rpc);
        if (e.mv) chk("n_ex_pc", n_epc_s, e.epc);
      end
    end
  end

  initial begin
    int waited;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; if_valid = 1'b0; if_pc = 32'h0; if_pred_taken = 1'b0; if_pred_pc = 32'h0;
    stall = 1'b0; ex_is_cond = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_cond_true = 1'b0; ex_target = 32'h0;
    m_id = '{1'b0, 32'h0, 1'b0, 32'h0};
    m_ex = '{1'b0, 32'h0, 1'b0, 32'h0};
    m_cb = 0; m_cm = 0;
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
    idle(1'b0); idle(1'b0);
    // Correctly predicted taken conditional, then the same branch falling through.
    step(1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 1'b1, 32'h140, 1'b0);
    step(1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 1'b0, 32'h140, 1'b0);
    idle(1'b0);
    // JALR predicted not-taken, then JAL with a matching predicted target.
    step(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3, 1'b0, 32'h3F0, 1'b0);
    step(1'b1, 32'h300, 1'b1, 32'h380, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2, 1'b0, 32'h380, 1'b0);
    // Two stall cycles holding 0x400 in ID.
    step(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h404, 1'b0, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h404, 1'b0, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 1'b0, 32'h0, 1'b0);
    idle(1'b0); idle(1'b0);
    // Mispredict while stalled: flush must win.
    step(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h504, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h508, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h600, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 1'b1, 32'h0, 1'b0);
    idle(1'b0);
    // Fall-through PC wraps at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 1'b0, 32'h10, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 1'b1, 32'h0, 1'b1);
      end else begin
        rand_step();
      end
    end
    idle(1'b0);
    waited = 0;
    while ((exp_q.size() > 0) && (waited < 10)) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
